// File: rtl/comms_tx_engine.sv
// rtl/comms_tx_engine.sv - Frame buffer, request/grant handshake and packet transmitter
module comms_tx_engine #(
   parameter int ID_W      = 16,
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 8,
   parameter int LIFO      = 1,
   parameter int TIMEOUT   = 8,
   parameter int MAX_RETRY = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ID_W-1:0]          node_id,
   input  logic                     gpp_trf_dp,
   input  logic [DATA_W-1:0]        gpp_tx_data,
   input  logic [ID_W-1:0]          gpp_tx_dest,
   input  logic [ID_W+DATA_W-1:0]   control_rx_packet,
   output logic [ID_W+DATA_W-1:0]   control_tx_packet,
   output logic [ID_W+DATA_W-1:0]   data_tx_packet,
   output logic                     tx_busy,
   output logic                     tx_done,
   output logic                     tx_error,
   output logic                     overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT_GNT, SEND} state_t;

   state_t             state;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   remaining;
   logic [PTR_W-1:0]   rd_ptr;
   logic [TMR_W-1:0]   timer;
   logic [RTY_W-1:0]   retries;
   logic [ID_W-1:0]    dest;
   logic               grant;
   logic               full;

   assign grant = (control_rx_packet == {dest, {DATA_W{1'b1}}});
   assign full  = (count == CNT_W'(DEPTH));

   // Word storage; the write address is simply the running word count.
   always_ff @(posedge clk) begin
      if (!rst && gpp_trf_dp) begin
         if (state == IDLE)
            mem[0] <= gpp_tx_data;
         else if (state == LOAD && !full)
            mem[count[PTR_W-1:0]] <= gpp_tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         count             <= '0;
         remaining         <= '0;
         rd_ptr            <= '0;
         timer             <= '0;
         retries           <= '0;
         dest              <= '0;
         control_tx_packet <= '0;
         data_tx_packet    <= '0;
         tx_busy           <= 1'b0;
         tx_done           <= 1'b0;
         tx_error          <= 1'b0;
         overflow          <= 1'b0;
      end else begin
         control_tx_packet <= '0;
         data_tx_packet    <= '0;
         tx_done           <= 1'b0;
         tx_error          <= 1'b0;
         case (state)
            IDLE: begin
               if (gpp_trf_dp) begin
                  dest     <= gpp_tx_dest;
                  count    <= CNT_W'(1);
                  overflow <= 1'b0;
                  retries  <= '0;
                  timer    <= '0;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               if (gpp_trf_dp) begin
                  if (full)
                     overflow <= 1'b1;
                  else
                     count <= count + CNT_W'(1);
               end else begin
                  control_tx_packet <= {dest, DATA_W'(count)};
                  tx_busy           <= 1'b1;
                  state             <= REQ;
               end
            end
            REQ: begin
               timer <= '0;
               state <= WAIT_GNT;
            end
            WAIT_GNT: begin
               // A grant on the expiry cycle wins over the retry/abandon path.
               if (grant) begin
                  data_tx_packet <= {node_id, DATA_W'(count)};
                  rd_ptr         <= (LIFO != 0) ? PTR_W'(count - CNT_W'(1)) : '0;
                  remaining      <= count;
                  state          <= SEND;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  timer <= '0;
                  if (retries == RTY_W'(MAX_RETRY)) begin
                     tx_error <= 1'b1;
                     tx_busy  <= 1'b0;
                     count    <= '0;
                     state    <= IDLE;
                  end else begin
                     retries           <= retries + RTY_W'(1);
                     control_tx_packet <= {dest, DATA_W'(count)};
                     state             <= REQ;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            SEND: begin
               if (remaining != '0) begin
                  data_tx_packet <= {node_id, mem[rd_ptr]};
                  rd_ptr         <= (LIFO != 0) ? rd_ptr - PTR_W'(1) : rd_ptr + PTR_W'(1);
                  remaining      <= remaining - CNT_W'(1);
               end else begin
                  tx_done <= 1'b1;
                  tx_busy <= 1'b0;
                  count   <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comms_tx_engine.sv
// tb/tb_comms_tx_engine.sv - Self-checking bench: LIFO and FIFO instances driven in lockstep against a queue model
module tb_comms_tx_engine;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 8;
   localparam logic [15:0] NODE = 16'h0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] node_id = NODE;
   logic        gpp_trf_dp;
   logic [15:0] gpp_tx_data;
   logic [15:0] gpp_tx_dest;
   logic [31:0] control_rx_packet;
   logic [31:0] ctl_l, ctl_f, dat_l, dat_f;
   logic        busy_l, busy_f, done_l, done_f, err_l, err_f, ovf_l, ovf_f;

   int errors = 0;
   int checks = 0;
   logic [15:0] model_q[$];
   bit          exp_ovf;

   always #5 clk = ~clk;

   comms_tx_engine #(.LIFO(1)) dut_lifo (
      .clk(clk), .rst(rst), .node_id(node_id), .gpp_trf_dp(gpp_trf_dp),
      .gpp_tx_data(gpp_tx_data), .gpp_tx_dest(gpp_tx_dest),
      .control_rx_packet(control_rx_packet), .control_tx_packet(ctl_l),
      .data_tx_packet(dat_l), .tx_busy(busy_l), .tx_done(done_l),
      .tx_error(err_l), .overflow(ovf_l));

   comms_tx_engine #(.LIFO(0)) dut_fifo (
      .clk(clk), .rst(rst), .node_id(node_id), .gpp_trf_dp(gpp_trf_dp),
      .gpp_tx_data(gpp_tx_data), .gpp_tx_dest(gpp_tx_dest),
      .control_rx_packet(control_rx_packet), .control_tx_packet(ctl_f),
      .data_tx_packet(dat_f), .tx_busy(busy_f), .tx_done(done_f),
      .tx_error(err_f), .overflow(ovf_f));

   task automatic cyc();
      @(negedge clk);
   endtask

   function automatic logic [31:0] noise(input logic [15:0] dest);
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = {dest ^ 16'h0003, 16'hFFFF};
      if (v == {dest, 16'hFFFF}) v = v ^ 32'h1;
      return v;
   endfunction

   // Writes n words; directed frames use 000A, 000B, ...
   task automatic load_frame(input int n, input logic [15:0] dest, input bit directed);
      logic [15:0] w;
      model_q.delete();
      for (int i = 0; i < n; i++) begin
         w = directed ? 16'h000A + 16'(i) : 16'($urandom);
         gpp_trf_dp  = 1'b1;
         gpp_tx_data = w;
         gpp_tx_dest = (i == 0) ? dest : 16'($urandom);
         if (model_q.size() < DEPTH) model_q.push_back(w);
         cyc();
      end
      gpp_trf_dp  = 1'b0;
      gpp_tx_dest = 16'($urandom);
      exp_ovf     = (n > DEPTH);
   endtask

   task automatic check_req(input logic [15:0] dest);
      logic [31:0] exp;
      cyc();
      exp = {dest, 16'(model_q.size())};
      checks++;
      if (ctl_l !== exp || ctl_f !== exp) begin
         errors++;
         $display("FAIL req_packet: got %h/%h expected %h", ctl_l, ctl_f, exp);
      end
      checks++;
      if (ovf_l !== exp_ovf || ovf_f !== exp_ovf || busy_l !== 1'b1) begin
         errors++;
         $display("FAIL req_flags: ovf %b/%b busy %b expected ovf %b busy 1", ovf_l, ovf_f, busy_l, exp_ovf);
      end
   endtask

   // Called with the REQ cycle visible; grants in WAIT cycle delay+1.
   task automatic grant_and_send(input logic [15:0] dest, input int delay);
      int n;
      n = model_q.size();
      cyc();
      checks++;
      if (ctl_l !== 32'h0 || dat_l !== 32'h0) begin
         errors++;
         $display("FAIL wait_idle_outputs: ctl %h data %h expected 0", ctl_l, dat_l);
      end
      for (int j = 0; j < delay; j++) begin
         control_rx_packet = noise(dest);
         gpp_trf_dp        = 1'($urandom);
         gpp_tx_data       = 16'($urandom);
         cyc();
         checks++;
         if (ctl_l !== 32'h0 || busy_l !== 1'b1) begin
            errors++;
            $display("FAIL wait_cycle%0d: ctl %h busy %b expected 0/1", j, ctl_l, busy_l);
         end
      end
      control_rx_packet = {dest, 16'hFFFF};
      gpp_trf_dp        = 1'b0;
      cyc();
      control_rx_packet = 32'h0;
      checks++;
      if (dat_l !== {NODE, 16'(n)} || dat_f !== {NODE, 16'(n)}) begin
         errors++;
         $display("FAIL header: got %h/%h expected %h", dat_l, dat_f, {NODE, 16'(n)});
      end
      for (int k = 0; k < n; k++) begin
         cyc();
         checks++;
         if (dat_l !== {NODE, model_q[n-1-k]} || dat_f !== {NODE, model_q[k]} || done_l !== 1'b0) begin
            errors++;
            $display("FAIL word%0d: lifo %h fifo %h expected %h/%h", k, dat_l, dat_f,
                     {NODE, model_q[n-1-k]}, {NODE, model_q[k]});
         end
      end
      cyc();
      checks++;
      if (dat_l !== 32'h0 || dat_f !== 32'h0 || done_l !== 1'b1 || done_f !== 1'b1 || busy_l !== 1'b0) begin
         errors++;
         $display("FAIL frame_end: data %h done %b/%b busy %b expected 0 1 0", dat_l, done_l, done_f, busy_l);
      end
      cyc();
      checks++;
      if (done_l !== 1'b0 || err_l !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width: done %b err %b expected 0 0", done_l, err_l);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      gpp_trf_dp = 1'b0; gpp_tx_data = '0; gpp_tx_dest = '0; control_rx_packet = '0;
      cyc(); cyc();
      checks++;
      if ({ctl_l, dat_l, busy_l, done_l, err_l, ovf_l} !== '0 || {ctl_f, dat_f, busy_f, done_f, err_f, ovf_f} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ctl %h data %h flags %b%b%b%b expected all 0", ctl_l, dat_l, busy_l, done_l, err_l, ovf_l);
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_directed();
      load_frame(4, 16'h0001, 1'b1);
      check_req(16'h0001);
      grant_and_send(16'h0001, 2);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 6; f++) begin
         logic [15:0] d;
         d = 16'($urandom);
         load_frame($urandom_range(1, DEPTH), d, 1'b0);
         check_req(d);
         grant_and_send(d, $urandom_range(0, TIMEOUT - 1));
      end
   endtask

   task automatic test_boundaries();
      load_frame(1, 16'h0042, 1'b0);
      check_req(16'h0042);
      grant_and_send(16'h0042, TIMEOUT - 1);
      load_frame(DEPTH, 16'h1234, 1'b0);
      check_req(16'h1234);
      grant_and_send(16'h1234, 0);
   endtask

   task automatic test_overflow();
      load_frame(10, 16'h0001, 1'b0);
      check_req(16'h0001);
      grant_and_send(16'h0001, 3);
      load_frame(2, 16'h0001, 1'b0);
      check_req(16'h0001);
      grant_and_send(16'h0001, 1);
   endtask

   task automatic test_retry();
      logic [31:0] req;
      load_frame(4, 16'h0001, 1'b1);
      check_req(16'h0001);
      req = {16'h0001, 16'h0004};
      for (int t = 1; t <= 3 * (TIMEOUT + 1); t++) begin
         control_rx_packet = noise(16'h0001);
         cyc();
         checks++;
         if (ctl_l !== ((t % (TIMEOUT + 1) == 0 && t < 3 * (TIMEOUT + 1)) ? req : 32'h0) ||
             err_l !== (t == 3 * (TIMEOUT + 1)) || err_f !== err_l ||
             busy_l !== (t < 3 * (TIMEOUT + 1)) || done_l !== 1'b0) begin
            errors++;
            $display("FAIL retry_t%0d: ctl %h err %b/%b busy %b done %b", t, ctl_l, err_l, err_f, busy_l, done_l);
         end
      end
      control_rx_packet = 32'h0;
      cyc();
      checks++;
      if (err_l !== 1'b0 || busy_l !== 1'b0) begin
         errors++;
         $display("FAIL error_pulse_width: err %b busy %b expected 0 0", err_l, busy_l);
      end
      load_frame(3, 16'h0001, 1'b0);
      check_req(16'h0001);
      grant_and_send(16'h0001, 4);
   endtask

   task automatic test_reset_mid_send();
      load_frame(3, 16'h0007, 1'b0);
      check_req(16'h0007);
      cyc();
      control_rx_packet = {16'h0007, 16'hFFFF};
      cyc();
      control_rx_packet = 32'h0;
      checks++;
      if (dat_l !== {NODE, 16'h0003}) begin
         errors++;
         $display("FAIL pre_reset_header: got %h expected %h", dat_l, {NODE, 16'h0003});
      end
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++;
      if ({ctl_l, dat_l, busy_l, done_l, err_l} !== '0 || {ctl_f, dat_f, busy_f, done_f, err_f} !== '0) begin
         errors++;
         $display("FAIL reset_mid_send: ctl %h data %h busy %b done %b err %b expected 0", ctl_l, dat_l, busy_l, done_l, err_l);
      end
      cyc();
      checks++;
      if (done_l !== 1'b0 || err_l !== 1'b0 || dat_l !== 32'h0) begin
         errors++;
         $display("FAIL post_reset_quiet: done %b err %b data %h expected 0", done_l, err_l, dat_l);
      end
      load_frame(5, 16'h0009, 1'b0);
      check_req(16'h0009);
      grant_and_send(16'h0009, 5);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_frames();
      test_boundaries();
      test_overflow();
      test_retry();
      test_reset_mid_send();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
